// File: rtl/nanorv32_alu_arb_pkg.sv
// nanorv32_alu_arb_pkg
//   Shared constants and types for the ALU arbiter slice:
//   - datapath / op-select widths and the ALU op-select encodings;
//   - default starvation bound for the low-priority port;
//   - slot and grant enumerations used by the arbiter and its response slots.
package nanorv32_alu_arb_pkg;

   localparam int NANORV32_DATA_MSB           = 31;
   localparam int NANORV32_MUX_SEL_ALU_OP_MSB = 3;
   localparam int NANORV32_ALU_ARB_STARVE_MAX = 4;

   typedef logic [NANORV32_MUX_SEL_ALU_OP_MSB:0] alu_op_t;

   localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_ADD         = 4'd0;
   localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_SUB         = 4'd1;
   localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_AND         = 4'd2;
   localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_OR          = 4'd3;
   localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_XOR         = 4'd4;
   localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_SLL         = 4'd5;
   localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_SRL         = 4'd6;
   localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_SRA         = 4'd7;
   localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_LT_SIGNED   = 4'd8;
   localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_LT_UNSIGNED = 4'd9;
   localparam alu_op_t NANORV32_MUX_SEL_ALU_OP_NOP         = 4'd15;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_P0,
      GRANT_P1
   } grant_e;

endpackage

// File: rtl/nanorv32_alu_rsp_slot.sv
// nanorv32_alu_rsp_slot
//   One registered response slot (EMPTY/FULL) in front of a requester.
//   A grant captures the ALU result into the slot; the requester drains it
//   with rsp_ready_i. A grant while draining reloads the slot so one op per
//   cycle can stream through.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   grant_i         this port owns the ALU this cycle
//   rsp_ready_i     requester consumes the held result
//   alu_res_i       ALU result to capture
//   alu_cond_i      ALU condition flag to capture
//   rsp_valid_o     slot FULL
//   rsp_res_o       held result
//   rsp_cond_o      held condition flag
module nanorv32_alu_rsp_slot
   import nanorv32_alu_arb_pkg::*;
#(
   parameter int DATA_W = NANORV32_DATA_MSB + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              grant_i,
   input  logic              rsp_ready_i,
   input  logic [DATA_W-1:0] alu_res_i,
   input  logic              alu_cond_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_res_o,
   output logic              rsp_cond_o
);

   slot_state_e       state_q, state_d;
   logic [DATA_W-1:0] res_q;
   logic              cond_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SLOT_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: the default assignment first keeps this combinational process
   // free of inferred latches on paths that do not change state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SLOT_EMPTY: if (grant_i)                 state_d = SLOT_FULL;
         SLOT_FULL:  if (rsp_ready_i && !grant_i) state_d = SLOT_EMPTY;
         default:                                 state_d = SLOT_EMPTY;
      endcase
   end

   // A grant is only possible when the slot is empty or draining, so loading
   // on every grant covers both fresh capture and back-to-back reload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q  <= '0;
         cond_q <= 1'b0;
      end else if (grant_i) begin
         res_q  <= alu_res_i;
         cond_q <= alu_cond_i;
      end
   end

   always_comb begin
      rsp_valid_o = (state_q == SLOT_FULL);
      rsp_res_o   = res_q;
      rsp_cond_o  = cond_q;
   end

endmodule

// File: rtl/nanorv32_alu_arb.sv
// nanorv32_alu_arb
//   Shares one external combinational nanorv32_alu between the execute stage
//   (port 0, high priority) and an auxiliary requester (port 1, low priority).
//   Each port owns a registered response slot; a starvation counter forces a
//   port-1 grant after STARVE_MAX consecutive port-0 wins while port 1 waits.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   pN_req_valid/ready            request handshake (ready = grant)
//   pN_req_op/a/b                 ALU op select and operands
//   pN_rsp_valid/ready            response handshake
//   pN_rsp_res/cond               registered ALU result and condition
//   alu_porta/portb/op_sel        drive to the shared ALU
//   alu_res/alu_cond              result from the shared ALU
module nanorv32_alu_arb
   import nanorv32_alu_arb_pkg::*;
#(
   parameter int DATA_W     = NANORV32_DATA_MSB + 1,
   parameter int OP_W       = NANORV32_MUX_SEL_ALU_OP_MSB + 1,
   parameter int STARVE_MAX = NANORV32_ALU_ARB_STARVE_MAX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req_valid,
   output logic              p0_req_ready,
   input  logic [OP_W-1:0]   p0_req_op,
   input  logic [DATA_W-1:0] p0_req_a,
   input  logic [DATA_W-1:0] p0_req_b,
   output logic              p0_rsp_valid,
   input  logic              p0_rsp_ready,
   output logic [DATA_W-1:0] p0_rsp_res,
   output logic              p0_rsp_cond,
   input  logic              p1_req_valid,
   output logic              p1_req_ready,
   input  logic [OP_W-1:0]   p1_req_op,
   input  logic [DATA_W-1:0] p1_req_a,
   input  logic [DATA_W-1:0] p1_req_b,
   output logic              p1_rsp_valid,
   input  logic              p1_rsp_ready,
   output logic [DATA_W-1:0] p1_rsp_res,
   output logic              p1_rsp_cond,
   output logic [DATA_W-1:0] alu_porta,
   output logic [DATA_W-1:0] alu_portb,
   output logic [OP_W-1:0]   alu_op_sel,
   input  logic [DATA_W-1:0] alu_res,
   input  logic              alu_cond
);

   localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic             elig0, elig1;
   logic             grant0, grant1;
   grant_e           grant_sel;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   // A port may issue only when its slot is empty or being drained now.
   assign elig0 = p0_req_valid && (!p0_rsp_valid || p0_rsp_ready);
   assign elig1 = p1_req_valid && (!p1_rsp_valid || p1_rsp_ready);

   always_comb begin
      grant_sel = GRANT_NONE;
      if (elig0 && elig1) begin
         grant_sel = (starve_cnt_q == STARVE_LIM) ? GRANT_P1 : GRANT_P0;
      end else if (elig0) begin
         grant_sel = GRANT_P0;
      end else if (elig1) begin
         grant_sel = GRANT_P1;
      end
   end

   assign grant0       = (grant_sel == GRANT_P0);
   assign grant1       = (grant_sel == GRANT_P1);
   assign p0_req_ready = grant0;
   assign p1_req_ready = grant1;

   // Idle ALU sees a NOP with zero operands to keep its inputs quiet.
   always_comb begin
      alu_op_sel = OP_W'(NANORV32_MUX_SEL_ALU_OP_NOP);
      alu_porta  = '0;
      alu_portb  = '0;
      case (grant_sel)
         GRANT_P0: begin
            alu_op_sel = p0_req_op;
            alu_porta  = p0_req_a;
            alu_portb  = p0_req_b;
         end
         GRANT_P1: begin
            alu_op_sel = p1_req_op;
            alu_porta  = p1_req_a;
            alu_portb  = p1_req_b;
         end
         default: ;
      endcase
   end

   // Counts consecutive port-0 wins while port 1 is eligible; clears as soon
   // as port 1 is served or stops waiting.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant1 || !elig1) begin
         starve_cnt_d = '0;
      end else if (grant0 && (starve_cnt_q != STARVE_LIM)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   nanorv32_alu_rsp_slot #(
      .DATA_W (DATA_W)
   ) u_slot0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .grant_i     (grant0),
      .rsp_ready_i (p0_rsp_ready),
      .alu_res_i   (alu_res),
      .alu_cond_i  (alu_cond),
      .rsp_valid_o (p0_rsp_valid),
      .rsp_res_o   (p0_rsp_res),
      .rsp_cond_o  (p0_rsp_cond)
   );

   nanorv32_alu_rsp_slot #(
      .DATA_W (DATA_W)
   ) u_slot1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .grant_i     (grant1),
      .rsp_ready_i (p1_rsp_ready),
      .alu_res_i   (alu_res),
      .alu_cond_i  (alu_cond),
      .rsp_valid_o (p1_rsp_valid),
      .rsp_res_o   (p1_rsp_res),
      .rsp_cond_o  (p1_rsp_cond)
   );

endmodule

// File: tb/tb_nanorv32_alu_arb.sv
// tb_nanorv32_alu_arb
//   Directed scenarios plus randomized traffic against a transaction-level
//   reference of the arbiter. A behavioural ALU closes the loop on the
//   alu_* ports.
module tb_nanorv32_alu_arb;
   import nanorv32_alu_arb_pkg::*;

   localparam int DATA_W     = 32;
   localparam int OP_W       = 4;
   localparam int STARVE_MAX = 4;

   logic              clk;
   logic              rst_n;
   logic              p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_ready, p0_rsp_cond;
   logic              p1_req_valid, p1_req_ready, p1_rsp_valid, p1_rsp_ready, p1_rsp_cond;
   alu_op_t           p0_req_op, p1_req_op, alu_op_sel;
   logic [DATA_W-1:0] p0_req_a, p0_req_b, p0_rsp_res;
   logic [DATA_W-1:0] p1_req_a, p1_req_b, p1_rsp_res;
   logic [DATA_W-1:0] alu_porta, alu_portb, alu_res;
   logic              alu_cond;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference view of the block: per-port held response and how many
   // times port 0 has beaten a waiting port 1 in a row.
   logic        m_full [2];
   logic [31:0] m_res  [2];
   logic        m_cond [2];
   int          m_wait;

   // Values seen at the most recent mid-cycle sample.
   logic        smp_rdy0, smp_rdy1;

   nanorv32_alu_arb #(
      .DATA_W     (DATA_W),
      .OP_W       (OP_W),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .p0_req_valid (p0_req_valid),
      .p0_req_ready (p0_req_ready),
      .p0_req_op    (p0_req_op),
      .p0_req_a     (p0_req_a),
      .p0_req_b     (p0_req_b),
      .p0_rsp_valid (p0_rsp_valid),
      .p0_rsp_ready (p0_rsp_ready),
      .p0_rsp_res   (p0_rsp_res),
      .p0_rsp_cond  (p0_rsp_cond),
      .p1_req_valid (p1_req_valid),
      .p1_req_ready (p1_req_ready),
      .p1_req_op    (p1_req_op),
      .p1_req_a     (p1_req_a),
      .p1_req_b     (p1_req_b),
      .p1_rsp_valid (p1_rsp_valid),
      .p1_rsp_ready (p1_rsp_ready),
      .p1_rsp_res   (p1_rsp_res),
      .p1_rsp_cond  (p1_rsp_cond),
      .alu_porta    (alu_porta),
      .alu_portb    (alu_portb),
      .alu_op_sel   (alu_op_sel),
      .alu_res      (alu_res),
      .alu_cond     (alu_cond)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_ref(alu_op_t op, logic [31:0] a, logic [31:0] b);
      case (op)
         NANORV32_MUX_SEL_ALU_OP_ADD:         return a + b;
         NANORV32_MUX_SEL_ALU_OP_SUB:         return a - b;
         NANORV32_MUX_SEL_ALU_OP_AND:         return a & b;
         NANORV32_MUX_SEL_ALU_OP_OR:          return a | b;
         NANORV32_MUX_SEL_ALU_OP_XOR:         return a ^ b;
         NANORV32_MUX_SEL_ALU_OP_SLL:         return a << b[4:0];
         NANORV32_MUX_SEL_ALU_OP_SRL:         return a >> b[4:0];
         NANORV32_MUX_SEL_ALU_OP_SRA:         return $unsigned($signed(a) >>> b[4:0]);
         NANORV32_MUX_SEL_ALU_OP_LT_SIGNED:   return {31'b0, $signed(a) < $signed(b)};
         NANORV32_MUX_SEL_ALU_OP_LT_UNSIGNED: return {31'b0, a < b};
         default:                             return 32'h0;
      endcase
   endfunction

   // Behavioural ALU sitting outside the arbiter.
   always_comb begin
      alu_res  = alu_ref(alu_op_sel, alu_porta, alu_portb);
      alu_cond = |alu_res;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         m_full[p] = 1'b0;
         m_res[p]  = '0;
         m_cond[p] = 1'b0;
      end
      m_wait = 0;
   endtask

   task automatic set_p0(input logic v, input alu_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic rr);
      p0_req_valid = v; p0_req_op = op; p0_req_a = a; p0_req_b = b; p0_rsp_ready = rr;
   endtask

   task automatic set_p1(input logic v, input alu_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic rr);
      p1_req_valid = v; p1_req_op = op; p1_req_a = a; p1_req_b = b; p1_rsp_ready = rr;
   endtask

   // One clock: predict the grant from the current inputs, compare every
   // output mid-cycle, then advance the reference at the rising edge.
   task automatic step();
      logic        e0, e1, g0, g1;
      alu_op_t     x_op;
      logic [31:0] x_a, x_b, r;
      e0 = p0_req_valid && (!m_full[0] || p0_rsp_ready);
      e1 = p1_req_valid && (!m_full[1] || p1_rsp_ready);
      g1 = e1 && (!e0 || m_wait == STARVE_MAX);
      g0 = e0 && !g1;
      x_op = NANORV32_MUX_SEL_ALU_OP_NOP; x_a = '0; x_b = '0;
      if (g0) begin x_op = p0_req_op; x_a = p0_req_a; x_b = p0_req_b; end
      if (g1) begin x_op = p1_req_op; x_a = p1_req_a; x_b = p1_req_b; end

      @(negedge clk);
      smp_rdy0 = p0_req_ready;
      smp_rdy1 = p1_req_ready;
      check("p0_req_ready", p0_req_ready, g0);
      check("p1_req_ready", p1_req_ready, g1);
      check("alu_op_sel",   alu_op_sel,   x_op);
      check("alu_porta",    alu_porta,    x_a);
      check("alu_portb",    alu_portb,    x_b);
      check("p0_rsp_valid", p0_rsp_valid, m_full[0]);
      check("p0_rsp_res",   p0_rsp_res,   m_res[0]);
      check("p0_rsp_cond",  p0_rsp_cond,  m_cond[0]);
      check("p1_rsp_valid", p1_rsp_valid, m_full[1]);
      check("p1_rsp_res",   p1_rsp_res,   m_res[1]);
      check("p1_rsp_cond",  p1_rsp_cond,  m_cond[1]);

      @(posedge clk);
      if (g0) begin
         r = alu_ref(p0_req_op, p0_req_a, p0_req_b);
         m_full[0] = 1'b1; m_res[0] = r; m_cond[0] = |r;
      end else if (m_full[0] && p0_rsp_ready) begin
         m_full[0] = 1'b0;
      end
      if (g1) begin
         r = alu_ref(p1_req_op, p1_req_a, p1_req_b);
         m_full[1] = 1'b1; m_res[1] = r; m_cond[1] = |r;
      end else if (m_full[1] && p1_rsp_ready) begin
         m_full[1] = 1'b0;
      end
      if (g1 || !e1)                     m_wait = 0;
      else if (g0 && m_wait < STARVE_MAX) m_wait = m_wait + 1;
      #1;
   endtask

   task automatic idle();
      set_p0(1'b0, NANORV32_MUX_SEL_ALU_OP_ADD, '0, '0, 1'b1);
      set_p1(1'b0, NANORV32_MUX_SEL_ALU_OP_ADD, '0, '0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      model_reset();
      #12;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset state
      check("rst_p0_valid", p0_rsp_valid, 1'b0);
      check("rst_p1_valid", p1_rsp_valid, 1'b0);
      check("rst_p0_res",   p0_rsp_res,   32'h0);
      check("rst_p1_res",   p1_rsp_res,   32'h0);

      // Single p0 ADD 5+3
      set_p0(1'b1, NANORV32_MUX_SEL_ALU_OP_ADD, 32'h5, 32'h3, 1'b1);
      step();
      check("add_ready_T",  smp_rdy0, 1'b1);
      check("add_valid_T1", p0_rsp_valid, 1'b1);
      check("add_res_T1",   p0_rsp_res, 32'h8);
      check("add_cond_T1",  p0_rsp_cond, 1'b1);
      set_p0(1'b0, NANORV32_MUX_SEL_ALU_OP_ADD, '0, '0, 1'b1);
      step();
      check("add_valid_T2", p0_rsp_valid, 1'b0);

      // Idle: ALU sees NOP with zero operands
      idle();
      repeat (2) step();
      check("idle_op",    alu_op_sel, NANORV32_MUX_SEL_ALU_OP_NOP);
      check("idle_a",     alu_porta,  32'h0);
      check("idle_b",     alu_portb,  32'h0);
      check("idle_valid", p0_rsp_valid | p1_rsp_valid, 1'b0);

      // Contention: four p0 wins then one forced p1 grant, repeating
      set_p0(1'b1, NANORV32_MUX_SEL_ALU_OP_SUB, 32'h7,  32'h7,  1'b1);
      set_p1(1'b1, NANORV32_MUX_SEL_ALU_OP_OR,  32'hF0, 32'h0F, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step();
         check("cont_grant1", smp_rdy1, (i % 5) == 4);
         check("cont_grant0", smp_rdy0, (i % 5) != 4);
         if ((i % 5) == 4) begin
            check("cont_p1_res",  p1_rsp_res,  32'hFF);
            check("cont_p1_cond", p1_rsp_cond, 1'b1);
         end else begin
            check("cont_p0_res",  p0_rsp_res,  32'h0);
            check("cont_p0_cond", p0_rsp_cond, 1'b0);
         end
      end

      // Backpressure on p1
      idle();
      repeat (2) step();
      set_p1(1'b1, NANORV32_MUX_SEL_ALU_OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0);
      step();
      check("bp_issue_ready", smp_rdy1, 1'b1);
      set_p1(1'b1, NANORV32_MUX_SEL_ALU_OP_ADD, 32'h1, 32'h2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold_ready", smp_rdy1, 1'b0);
         check("bp_hold_valid", p1_rsp_valid, 1'b1);
         check("bp_hold_res",   p1_rsp_res, 32'h5A5A_5A5A);
      end
      p1_rsp_ready = 1'b1;
      step();
      check("bp_drain_ready", smp_rdy1, 1'b1);
      check("bp_drain_valid", p1_rsp_valid, 1'b1);
      check("bp_drain_res",   p1_rsp_res, 32'h3);

      // Signed compare pass-through
      idle();
      repeat (2) step();
      set_p0(1'b1, NANORV32_MUX_SEL_ALU_OP_LT_SIGNED, 32'hFFFF_FFFF, 32'h1, 1'b1);
      step();
      check("lts_res",  p0_rsp_res,  32'h1);
      check("lts_cond", p0_rsp_cond, 1'b1);

      // Reset mid-operation with p0 FULL and three port-0 wins counted
      idle();
      repeat (2) step();
      set_p0(1'b1, NANORV32_MUX_SEL_ALU_OP_ADD, 32'h5, 32'h3, 1'b1);
      set_p1(1'b1, NANORV32_MUX_SEL_ALU_OP_OR,  32'hF0, 32'h0F, 1'b1);
      repeat (3) step();
      check("pre_rst_cnt", dut.starve_cnt_q, 3);
      check("pre_rst_res", p0_rsp_res, 32'h8);
      rst_n = 1'b0;
      #1;
      check("arst_p0_valid", p0_rsp_valid, 1'b0);
      check("arst_p0_res",   p0_rsp_res,   32'h0);
      check("arst_cnt",      dut.starve_cnt_q, 0);
      idle();
      model_reset();
      #1;
      rst_n = 1'b1;
      set_p1(1'b1, NANORV32_MUX_SEL_ALU_OP_ADD, 32'h10, 32'h20, 1'b1);
      step();
      check("post_rst_p1_grant", smp_rdy1, 1'b1);
      check("post_rst_p1_res",   p1_rsp_res, 32'h30);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         set_p0($urandom_range(0, 9) < 7, alu_op_t'($urandom_range(0, 15)),
                $urandom, $urandom, $urandom_range(0, 9) < 6);
         set_p1($urandom_range(0, 9) < 7, alu_op_t'($urandom_range(0, 15)),
                $urandom, $urandom, $urandom_range(0, 9) < 6);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
